alu_op_sequencer: RTL and testbench

- Issues ALU operations to the A/B/Y register file: accepts instructions over a valid/ready handshake and buffers them in a small FIFO.
- Drives the three 4-bit mux selects and three write enables one instruction at a time.
- Sits between the instruction source and the A/B/Y mux-register datapath.
- Owns the sequencing of two-phase SWP and the CMP destination override.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_op_sequencer_sync_fifo.sv | 72 +++++++
 rtl/alu_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer:
//   - 4-bit opcode constants OP_ADD .. OP_SWP
//   - bit positions of the {Y,B,A} destination mask
//   - width of one buffered instruction ({dst, op})
//   - FSM state encoding for the issue sequencer
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_INV  = 4'd12;
  localparam logic [3:0] OP_NEG  = 4'd13;
  localparam logic [3:0] OP_STO  = 4'd14;
  localparam logic [3:0] OP_SWP  = 4'd15;

  // Destination mask bit positions, mask is packed as {Y,B,A}
  localparam int DST_A = 0;
  localparam int DST_B = 1;
  localparam int DST_Y = 2;

  // One buffered instruction is {dst[2:0], op[3:0]}
  localparam int INSTR_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SWP2  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO with first-word fall-through read data.
// Ports:
//   clk, reset      - clock and synchronous active-high reset (empties FIFO)
//   i_push          - write i_pushData when not full
//   i_pushData      - entry to store
//   i_pop           - advance the read pointer when not empty
//   o_popData       - entry at the head of the FIFO (valid when !o_empty)
//   o_full, o_empty - occupancy flags, derived from the registered count
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_popData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Full is taken from the registered count only, so a pop in the same
  // cycle never opens a slot for that cycle's push.
  assign o_full    = (r_count == DEPTH_CNT);
  assign o_empty   = (r_count == '0);
  assign w_doPush  = i_push && !o_full;
  assign w_doPop   = i_pop && !o_empty;
  assign o_popData = r_mem[r_rdPtr];

  // Storage array; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Buffers ALU instructions and issues them, one per cycle, to the A/B/Y
// mux-register datapath. SWP is issued in two phases (A then B) and CMP
// always writes Y only.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   instr_valid/ready - instruction handshake (ready = FIFO not full)
//   instr_op          - 4-bit opcode
//   instr_dst         - destination mask {Y,B,A}
//   stall             - blocks new issues while high
//   sel_A/B/Y         - registered mux selects
//   enable_A/B/Y      - registered write enables
//   busy              - FIFO non-empty or an instruction in flight
//   done              - one-cycle pulse per retired instruction
//   retired_count     - wrapping count of retired instructions
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [2:0]       instr_dst,
  input  logic             stall,
  output logic [3:0]       sel_A,
  output logic [3:0]       sel_B,
  output logic [3:0]       sel_Y,
  output logic             enable_A,
  output logic             enable_B,
  output logic             enable_Y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired_count
);

  seq_state_t       r_state;
  logic [3:0]       r_sel;
  logic [2:0]       r_en;
  logic             r_done;
  logic             r_isSwp;
  logic             r_swpEnB;
  logic [CNT_W-1:0] r_retired;

  seq_state_t       w_nextState;
  logic [3:0]       w_nextSel;
  logic [2:0]       w_nextEn;
  logic             w_nextDone;
  logic             w_nextIsSwp;
  logic             w_nextSwpEnB;
  logic             w_pop;
  logic             w_push;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic [INSTR_W-1:0] w_head;
  logic [3:0]       w_headOp;
  logic [2:0]       w_headDst;

  // Enables for the first (or only) issue cycle of an instruction.
  // CMP always targets Y; SWP writes only A in its first phase.
  function automatic logic [2:0] decodeEnables(input logic [3:0] op,
                                               input logic [2:0] dst);
    logic [2:0] en;
    en = dst;
    if (op == OP_CMP) begin
      en = 3'b000;
      en[DST_Y] = 1'b1;
    end else if (op == OP_SWP) begin
      en = 3'b000;
      en[DST_A] = dst[DST_A];
    end
    return en;
  endfunction

  assign w_push      = instr_valid && !w_fifoFull;
  assign instr_ready = !w_fifoFull;
  assign w_headOp    = w_head[3:0];
  assign w_headDst   = w_head[6:4];

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pushData ({instr_dst, instr_op}),
    .i_pop      (w_pop),
    .o_popData  (w_head),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty)
  );

  // Next-state and next-output decode. The first phase of a SWP always
  // moves on to its second phase, even under stall; every other state is
  // a pop decision point where stall and FIFO occupancy decide whether a
  // new instruction issues. When nothing issues the selects hold.
  always_comb begin
    w_nextState  = r_state;
    w_nextSel    = r_sel;
    w_nextEn     = 3'b000;
    w_nextDone   = 1'b0;
    w_nextIsSwp  = r_isSwp;
    w_nextSwpEnB = r_swpEnB;
    w_pop        = 1'b0;

    if (r_state == ST_ISSUE && r_isSwp) begin
      w_nextState       = ST_SWP2;
      w_nextSel         = OP_SWP;
      w_nextEn[DST_B]   = r_swpEnB;
      w_nextDone        = 1'b1;
      w_nextIsSwp       = 1'b0;
    end else if (!w_fifoEmpty && !stall) begin
      w_pop        = 1'b1;
      w_nextState  = ST_ISSUE;
      w_nextSel    = w_headOp;
      w_nextEn     = decodeEnables(w_headOp, w_headDst);
      w_nextDone   = (w_headOp != OP_SWP);
      w_nextIsSwp  = (w_headOp == OP_SWP);
      w_nextSwpEnB = w_headDst[DST_B];
    end else begin
      w_nextState  = ST_IDLE;
    end
  end

  // State and output registers. The retired counter advances together
  // with the registered done pulse so both become visible in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sel     <= 4'd0;
      r_en      <= 3'b000;
      r_done    <= 1'b0;
      r_isSwp   <= 1'b0;
      r_swpEnB  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_nextState;
      r_sel     <= w_nextSel;
      r_en      <= w_nextEn;
      r_done    <= w_nextDone;
      r_isSwp   <= w_nextIsSwp;
      r_swpEnB  <= w_nextSwpEnB;
      r_retired <= r_retired + CNT_W'(w_nextDone);
    end
  end

  assign sel_A         = r_sel;
  assign sel_B         = r_sel;
  assign sel_Y         = r_sel;
  assign enable_A      = r_en[DST_A];
  assign enable_B      = r_en[DST_B];
  assign enable_Y      = r_en[DST_Y];
  assign done          = r_done;
  assign retired_count = r_retired;
  assign busy          = !w_fifoEmpty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Scoreboard bench for alu_op_sequencer: stimulus queues the hand-computed
// output beats it expects, a negedge monitor pops one entry for every cycle
// the DUT shows an enable or done. Direct checks cover reset, latency,
// stall, back-pressure and counter wrap.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [2:0] instr_dst;
  logic       stall;
  logic [3:0] sel_A;
  logic [3:0] sel_B;
  logic [3:0] sel_Y;
  logic       enable_A;
  logic       enable_B;
  logic       enable_Y;
  logic       busy;
  logic       done;
  logic [7:0] retired_count;

  typedef struct packed {
    logic [3:0] sel;
    logic [2:0] en;
    logic       done;
    logic [7:0] retired;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] modelRetired;
  int         checkCount;
  int         errorCount;

  // Hand-computed vectors: op, dst mask, expected sel and {Y,B,A} enables
  logic [3:0] vOp    [0:8] = '{4'd2, 4'd8, 4'd0, 4'd4, 4'd12, 4'd14, 4'd3, 4'd5, 4'd10};
  logic [2:0] vDst   [0:8] = '{3'b010, 3'b101, 3'b000, 3'b000, 3'b110, 3'b001, 3'b100, 3'b011, 3'b111};
  logic [2:0] vExpEn [0:8] = '{3'b010, 3'b101, 3'b000, 3'b100, 3'b110, 3'b001, 3'b100, 3'b011, 3'b111};

  // Instructions used while filling the FIFO under stall
  logic [3:0] fOp    [0:4] = '{4'd1, 4'd6, 4'd9, 4'd11, 4'd13};
  logic [2:0] fDst   [0:4] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b111};

  alu_op_sequencer #(
    .FIFO_DEPTH (4),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_dst     (instr_dst),
    .stall         (stall),
    .sel_A         (sel_A),
    .sel_B         (sel_B),
    .sel_Y         (sel_Y),
    .enable_A      (enable_A),
    .enable_B      (enable_B),
    .enable_Y      (enable_Y),
    .busy          (busy),
    .done          (done),
    .retired_count (retired_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by the monitor and the stimulus
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Queue one expected output beat; the model counter advances on done
  task automatic expectOut(input logic [3:0] sel, input logic [2:0] en, input logic dn);
    exp_t e;
    if (dn) modelRetired = modelRetired + 8'd1;
    e.sel     = sel;
    e.en      = en;
    e.done    = dn;
    e.retired = modelRetired;
    expQ.push_back(e);
  endtask

  // Offer one instruction and hold it until accepted (bounded wait)
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] dst);
    int waitCycles;
    waitCycles  = 0;
    instr_op    = op;
    instr_dst   = dst;
    instr_valid = 1'b1;
    while (!instr_ready && waitCycles < 200) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!instr_ready) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL push_timeout: got ready=0, expected ready=1");
    end else begin
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
  endtask

  // Wait for the sequencer to drain, bounded
  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle_timeout_busy", int'(busy), 0);
  endtask

  // Monitor: every cycle that shows an enable or done must match the next
  // queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (enable_A || enable_B || enable_Y || done) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpected_beat: got sel=%0d en=%b%b%b done=%0d, expected no output",
                 sel_A, enable_Y, enable_B, enable_A, done);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_sel_A", int'(sel_A), int'(e.sel));
        checkOutput("sb_sel_B", int'(sel_B), int'(e.sel));
        checkOutput("sb_sel_Y", int'(sel_Y), int'(e.sel));
        checkOutput("sb_enables", int'({enable_Y, enable_B, enable_A}), int'(e.en));
        checkOutput("sb_done", int'(done), int'(e.done));
        checkOutput("sb_retired", int'(retired_count), int'(e.retired));
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    modelRetired = 8'd0;
    reset        = 1'b1;
    instr_valid  = 1'b0;
    instr_op     = 4'd0;
    instr_dst    = 3'b000;
    stall        = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_ready", int'(instr_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_enables", int'({enable_Y, enable_B, enable_A}), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_sel", int'(sel_A), 0);
    checkOutput("rst_retired", int'(retired_count), 0);

    // ADD to all three registers, with latency check
    expectOut(4'd0, 3'b111, 1'b1);
    applyStimulus(4'd0, 3'b111);
    checkOutput("add_busy_cycle0", int'(busy), 1);
    checkOutput("add_en_cycle0", int'({enable_Y, enable_B, enable_A}), 0);
    @(posedge clk); #1;
    checkOutput("add_en_cycle1", int'({enable_Y, enable_B, enable_A}), 7);
    checkOutput("add_done_cycle1", int'(done), 1);
    checkOutput("add_retired_cycle1", int'(retired_count), 1);
    @(posedge clk); #1;
    checkOutput("add_busy_cycle2", int'(busy), 0);
    checkOutput("add_done_cycle2", int'(done), 0);

    // CMP ignores its mask and writes Y only
    expectOut(4'd4, 3'b100, 1'b1);
    applyStimulus(4'd4, 3'b011);
    @(posedge clk); #1;
    checkOutput("cmp_sel_Y", int'(sel_Y), 4);
    checkOutput("cmp_enables", int'({enable_Y, enable_B, enable_A}), 4);
    waitIdle();

    // SWP then XOR back-to-back
    expectOut(4'd15, 3'b001, 1'b0);
    expectOut(4'd15, 3'b010, 1'b1);
    expectOut(4'd7,  3'b001, 1'b1);
    applyStimulus(4'd15, 3'b011);
    applyStimulus(4'd7, 3'b001);
    checkOutput("swp1_sel", int'(sel_A), 15);
    checkOutput("swp1_enables", int'({enable_Y, enable_B, enable_A}), 1);
    checkOutput("swp1_done", int'(done), 0);
    @(posedge clk); #1;
    checkOutput("swp2_enables", int'({enable_Y, enable_B, enable_A}), 2);
    checkOutput("swp2_done", int'(done), 1);
    @(posedge clk); #1;
    checkOutput("xor_sel", int'(sel_A), 7);
    checkOutput("xor_enables", int'({enable_Y, enable_B, enable_A}), 1);
    checkOutput("xor_done", int'(done), 1);
    waitIdle();

    // Table of assorted ops including NOP and CMP with empty mask, then a
    // SWP that has dst[0]=0 and dst[2]=1 (only the B phase shows up)
    for (int i = 0; i < 9; i++) begin
      expectOut(vOp[i], vExpEn[i], 1'b1);
      applyStimulus(vOp[i], vDst[i]);
    end
    expectOut(4'd15, 3'b010, 1'b1);
    applyStimulus(4'd15, 3'b110);
    waitIdle();

    // Stall raised during SWP first phase does not block the second phase
    expectOut(4'd15, 3'b001, 1'b0);
    expectOut(4'd15, 3'b010, 1'b1);
    applyStimulus(4'd15, 3'b011);
    @(posedge clk); #1;
    stall = 1'b1;
    checkOutput("swpstall_phase1_enA", int'(enable_A), 1);
    @(posedge clk); #1;
    checkOutput("swpstall_phase2_enB", int'(enable_B), 1);
    checkOutput("swpstall_phase2_done", int'(done), 1);
    @(posedge clk); #1;
    checkOutput("swpstall_after_en", int'({enable_Y, enable_B, enable_A}), 0);

    // Fill the FIFO while stalled; selects hold the last value
    for (int i = 0; i < 5; i++) begin
      expectOut(fOp[i], fDst[i], 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(fOp[i], fDst[i]);
    end
    checkOutput("full_ready", int'(instr_ready), 0);
    checkOutput("full_busy", int'(busy), 1);
    @(posedge clk); #1;
    checkOutput("stalled_enables", int'({enable_Y, enable_B, enable_A}), 0);
    checkOutput("stalled_done", int'(done), 0);
    checkOutput("stalled_sel_hold", int'(sel_B), 15);
    stall       = 1'b0;
    instr_op    = fOp[4];
    instr_dst   = fDst[4];
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) checkOutput("unstall_ready", int'(instr_ready), 1);
      if (i == 1) instr_valid = 1'b0;
      checkOutput("unstall_done_run", int'(done), 1);
    end
    waitIdle();

    // Reset during SWP first phase aborts it and empties the FIFO
    expectOut(4'd15, 3'b001, 1'b0);
    applyStimulus(4'd15, 3'b011);
    applyStimulus(4'd0, 3'b111);
    checkOutput("rstswp_phase1_enA", int'(enable_A), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelRetired = 8'd0;
    checkOutput("rstswp_queue_consumed", expQ.size(), 0);
    expQ.delete();
    checkOutput("rstswp_enables", int'({enable_Y, enable_B, enable_A}), 0);
    checkOutput("rstswp_done", int'(done), 0);
    checkOutput("rstswp_busy", int'(busy), 0);
    checkOutput("rstswp_retired", int'(retired_count), 0);
    @(posedge clk); #1;
    checkOutput("rstswp_no_phase2", int'({enable_Y, enable_B, enable_A, done}), 0);

    // Counter wrap: 255 NOPs then one more
    for (int i = 0; i < 255; i++) begin
      expectOut(4'd0, 3'b000, 1'b1);
      applyStimulus(4'd0, 3'b000);
    end
    waitIdle();
    checkOutput("wrap_at_255", int'(retired_count), 255);
    expectOut(4'd0, 3'b000, 1'b1);
    applyStimulus(4'd0, 3'b000);
    waitIdle();
    checkOutput("wrap_to_0", int'(retired_count), 0);

    @(posedge clk); #1;
    checkOutput("sb_queue_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
